// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: Din / D, one quotient bit per clock.
// The divisor register D is loaded separately and stays frozen while a division runs.
module seq_divider #(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Execute,
   input  logic             Load_Dvsr,
   input  logic [WIDTH-1:0] Din,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             Busy,
   output logic             Done,
   output logic             Div_By_Zero
);

   // state | meaning
   // IDLE  | waiting for Execute; Load_Dvsr may update D
   // ITER  | one shift-subtract step per cycle, WIDTH steps total
   // DONE  | results final; held until Execute drops
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH:0]   trial;
   logic             q_bit;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvsr_q  <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvsr_q  <= dvsr_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvsr_d  = dvsr_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      trial   = {rem_q, quot_q[WIDTH-1]};
      q_bit   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (Execute) begin
               if (dvsr_q != '0) begin
                  quot_d  = Din;
                  rem_d   = '0;
                  cnt_d   = '0;
                  dbz_d   = 1'b0;
                  state_d = ITER;
               end else begin
                  quot_d  = '1;
                  rem_d   = Din;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end
            end else if (Load_Dvsr) begin
               dvsr_d = Din;
            end
         end
         ITER: begin
            // Remainder < D before every step, so T - D always fits in WIDTH bits
            // and the low bits of the narrow subtraction are exact.
            if (trial >= {1'b0, dvsr_q}) begin
               rem_d = trial[WIDTH-1:0] - dvsr_q;
               q_bit = 1'b1;
            end else begin
               rem_d = trial[WIDTH-1:0];
            end
            quot_d = {quot_q[WIDTH-2:0], q_bit};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (!Execute) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign Quotient    = quot_q;
   assign Remainder   = rem_q;
   assign Div_By_Zero = dbz_q;
   assign Busy        = (state_q == ITER);
   assign Done        = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed plus randomized checks of seq_divider against an arithmetic
// reference (integer / and %, divide-by-zero convention) held in the bench.
module tb_seq_divider;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       Execute = 1'b0;
   logic       Load_Dvsr = 1'b0;
   logic [7:0] Din = 8'd0;
   logic [7:0] Quotient, Remainder;
   logic       Busy, Done, Div_By_Zero;

   int checks = 0;
   int errors = 0;
   int model_d = 0;

   seq_divider #(.WIDTH(8)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Execute    (Execute),
      .Load_Dvsr  (Load_Dvsr),
      .Din        (Din),
      .Quotient   (Quotient),
      .Remainder  (Remainder),
      .Busy       (Busy),
      .Done       (Done),
      .Div_By_Zero(Div_By_Zero)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      Execute = 1'b0;
      Load_Dvsr = 1'b0;
      step();
      Reset = 1'b0;
      model_d = 0;
      chk("rst_quot", int'(Quotient), 0);
      chk("rst_rem", int'(Remainder), 0);
      chk("rst_dbz", int'(Div_By_Zero), 0);
      chk("rst_busy", int'(Busy), 0);
      chk("rst_done", int'(Done), 0);
   endtask

   task automatic load(input int v);
      Load_Dvsr = 1'b1;
      Din = 8'(v);
      step();
      Load_Dvsr = 1'b0;
      model_d = v;
   endtask

   // Start a division, optionally scrambling Din/Load_Dvsr while it runs,
   // hold Execute for 'hold' extra cycles in DONE, then release and confirm IDLE.
   task automatic run_div(input string tag, input int dvd, input bit scramble, input int hold);
      int exp_q, exp_r, exp_z, exp_busy;
      int busy_cnt, bad_hold;
      if (model_d == 0) begin
         exp_q = 255; exp_r = dvd; exp_z = 1; exp_busy = 0;
      end else begin
         exp_q = dvd / model_d; exp_r = dvd % model_d; exp_z = 0; exp_busy = 8;
      end
      Execute = 1'b1;
      Din = 8'(dvd);
      step();
      busy_cnt = 0;
      while (Busy && busy_cnt < 20) begin
         if (Done) busy_cnt = 100;
         if (scramble) begin
            Din = 8'($urandom);
            Load_Dvsr = 1'($urandom);
         end
         step();
         busy_cnt++;
      end
      Load_Dvsr = 1'b0;
      chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
      chk({tag, "_done"}, int'(Done), 1);
      chk({tag, "_quot"}, int'(Quotient), exp_q);
      chk({tag, "_rem"}, int'(Remainder), exp_r);
      chk({tag, "_dbz"}, int'(Div_By_Zero), exp_z);
      if (hold > 0) begin
         bad_hold = 0;
         for (int i = 0; i < hold; i++) begin
            step();
            if (!Done || Busy || int'(Quotient) != exp_q || int'(Remainder) != exp_r) bad_hold++;
         end
         chk({tag, "_held_done"}, bad_hold, 0);
      end
      Execute = 1'b0;
      step();
      chk({tag, "_idle"}, int'({Busy, Done}), 0);
      chk({tag, "_hold_q"}, int'(Quotient), exp_q);
   endtask

   initial begin
      int d, v;

      do_reset();

      load(7);
      run_div("d7_100", 100, 1'b0, 0);

      load(1);
      run_div("d1_255", 255, 1'b0, 0);
      load(200);
      run_div("d200_200", 200, 1'b0, 0);
      load(9);
      run_div("d9_5", 5, 1'b0, 0);

      do_reset();
      run_div("dbz_42", 42, 1'b0, 0);

      load(13);
      run_div("held30", 250, 1'b0, 30);
      run_div("second", 77, 1'b0, 0);

      load(5);
      Execute = 1'b1;
      Din = 8'd123;
      step();
      step();
      step();
      step();
      chk("mid_iter_busy", int'(Busy), 1);
      Reset = 1'b1;
      Execute = 1'b0;
      step();
      Reset = 1'b0;
      model_d = 0;
      chk("midrst_outs", int'({Quotient, Remainder, Div_By_Zero, Busy, Done}), 0);
      run_div("midrst_dbz", 99, 1'b0, 0);

      load(11);
      run_div("scramble", 200, 1'b1, 2);
      run_div("d_unchanged", 100, 1'b0, 0);

      for (int k = 0; k < 20; k++) begin
         d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
         v = int'($urandom_range(0, 255));
         load(d);
         run_div("rand", v, 1'($urandom), int'($urandom_range(0, 3)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
